// File: rtl/cpu_mailbox.sv
// cpu_mailbox: 6502-bus 4-byte register window linking the CPU and FPGA logic through RX/TX byte FIFOs.
// Build option: define CPU_MAILBOX_IRQ_EN to enable the RX-not-empty interrupt and CTRL irq_en bit.
module cpu_mailbox #(
    parameter int DEPTH = 16,
    parameter int SYNC  = 2
) (
    input  logic       clk_src,
    input  logic       rst_n,
    input  logic       cpu_clk_out,
    input  logic       cs_n,
    input  logic       rw,
    input  logic [1:0] address,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       irq_n
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = 13;
    localparam logic [BW-1:0] BUS_IDLE  = {1'b0, 1'b1, 11'b0};
    localparam logic [AW:0]   CNT_EMPTY = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    // Bus bundle layout: {phi2, cs_n, rw, address[1:0], data_in[7:0]}
    logic [BW-1:0] sync_q [SYNC];
    logic [BW-2:0] lat_q;
    logic          phi2_prev_q;
    logic [BW-1:0] bus_s;
    logic          commit_s, lat_rw_s;
    logic [1:0]    lat_addr_s;
    logic [7:0]    lat_data_s;

    assign bus_s      = sync_q[SYNC-1];
    assign lat_rw_s   = lat_q[10];
    assign lat_addr_s = lat_q[9:8];
    assign lat_data_s = lat_q[7:0];
    assign commit_s   = phi2_prev_q & ~bus_s[BW-1] & ~lat_q[11];

    // Synchronize bus pins, latch the sampled set during PHI2 high, track PHI2 for the falling edge
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= BUS_IDLE;
            lat_q       <= BUS_IDLE[BW-2:0];
            phi2_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {cpu_clk_out, cs_n, rw, address, data_in};
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
            if (bus_s[BW-1]) lat_q <= bus_s[BW-2:0];
            else             lat_q <= lat_q;
            phi2_prev_q <= bus_s[BW-1];
        end
    end

    logic rd_data_s, wr_data_s, wr_ctrl_s, flush_s, clr_s;
    assign rd_data_s = commit_s &  lat_rw_s & (lat_addr_s == 2'd0);
    assign wr_data_s = commit_s & ~lat_rw_s & (lat_addr_s == 2'd0);
    assign wr_ctrl_s = commit_s & ~lat_rw_s & (lat_addr_s == 2'd2);
    assign flush_s   = wr_ctrl_s & lat_data_s[1];
    assign clr_s     = wr_ctrl_s & lat_data_s[0];

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
    logic [AW:0]   rx_cnt_q, tx_cnt_q;
    logic          rx_ovf_q, tx_ovf_q;
    logic          rx_full_s, rx_nempty_s, tx_full_s;
    logic          rx_push_s, rx_pop_s, rx_drop_s, tx_push_s, tx_pop_s, tx_drop_s;

    assign rx_full_s   = (rx_cnt_q == CNT_FULL);
    assign rx_nempty_s = (rx_cnt_q != CNT_EMPTY);
    assign tx_full_s   = (tx_cnt_q == CNT_FULL);
    assign tx_valid    = (tx_cnt_q != CNT_EMPTY);
    assign rx_ready    = ~rx_full_s;
    assign tx_data     = tx_valid ? tx_mem[tx_rp_q] : 8'h00;

    // A pop in the same clock frees a slot, so a push into a full FIFO is still accepted
    assign rx_pop_s  = rd_data_s & rx_nempty_s;
    assign rx_push_s = rx_valid & (~rx_full_s | rx_pop_s);
    assign rx_drop_s = rx_valid & rx_full_s & ~rx_pop_s;
    assign tx_pop_s  = tx_ready & tx_valid;
    assign tx_push_s = wr_data_s & (~tx_full_s | tx_pop_s);
    assign tx_drop_s = wr_data_s & tx_full_s & ~tx_pop_s;

    // FIFO storage writes
    always_ff @(posedge clk_src) begin
        if (rx_push_s & ~flush_s) rx_mem[rx_wp_q] <= rx_data;
        if (tx_push_s & ~flush_s) tx_mem[tx_wp_q] <= lat_data_s;
    end

    // FIFO pointers, counts and sticky overflow flags; flush and clear take priority
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp_q <= PTR_ZERO; rx_rp_q <= PTR_ZERO; rx_cnt_q <= CNT_EMPTY;
            tx_wp_q <= PTR_ZERO; tx_rp_q <= PTR_ZERO; tx_cnt_q <= CNT_EMPTY;
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else begin
            if (flush_s) begin
                rx_wp_q <= PTR_ZERO; rx_rp_q <= PTR_ZERO; rx_cnt_q <= CNT_EMPTY;
                tx_wp_q <= PTR_ZERO; tx_rp_q <= PTR_ZERO; tx_cnt_q <= CNT_EMPTY;
            end else begin
                if (rx_push_s) rx_wp_q <= rx_wp_q + PTR_ONE;
                if (rx_pop_s)  rx_rp_q <= rx_rp_q + PTR_ONE;
                rx_cnt_q <= rx_cnt_q + (AW+1)'(rx_push_s) - (AW+1)'(rx_pop_s);
                if (tx_push_s) tx_wp_q <= tx_wp_q + PTR_ONE;
                if (tx_pop_s)  tx_rp_q <= tx_rp_q + PTR_ONE;
                tx_cnt_q <= tx_cnt_q + (AW+1)'(tx_push_s) - (AW+1)'(tx_pop_s);
            end
            if (clr_s)                     rx_ovf_q <= 1'b0;
            else if (rx_drop_s & ~flush_s) rx_ovf_q <= 1'b1;
            else                           rx_ovf_q <= rx_ovf_q;
            if (clr_s)                     tx_ovf_q <= 1'b0;
            else if (tx_drop_s & ~flush_s) tx_ovf_q <= 1'b1;
            else                           tx_ovf_q <= tx_ovf_q;
        end
    end

    logic irq_en_s;
`ifdef CPU_MAILBOX_IRQ_EN
    logic irq_en_q, irq_n_q;
    assign irq_en_s = irq_en_q;
    assign irq_n    = irq_n_q;

    // Interrupt enable and registered active-low request while RX holds data
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
            irq_n_q  <= 1'b1;
        end else begin
            if (wr_ctrl_s) irq_en_q <= lat_data_s[2];
            else           irq_en_q <= irq_en_q;
            irq_n_q <= ~(irq_en_q & rx_nempty_s);
        end
    end
`else
    assign irq_en_s = 1'b0;
    assign irq_n    = 1'b1;
`endif

    logic [7:0] status_s, rx_head_s;
    assign status_s  = {4'b0000, tx_ovf_q, rx_ovf_q, tx_full_s, rx_nempty_s};
    assign rx_head_s = rx_nempty_s ? rx_mem[rx_rp_q] : 8'h00;
    assign data_oe   = ~cs_n & rw & cpu_clk_out;

    // Read mux driven by the raw CPU address
    always_comb begin
        data_out = 8'h00;
        case (address)
            2'd0:    data_out = rx_head_s;
            2'd1:    data_out = status_s;
            2'd2:    data_out = {5'b00000, irq_en_s, 2'b00};
            default: data_out = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_cpu_mailbox.sv
// tb_cpu_mailbox: directed and randomized bench for cpu_mailbox against a queue-based reference model.
module tb_cpu_mailbox;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;

    logic       clk_src = 1'b0;
    logic       rst_n, cpu_clk_out, cs_n, rw, rx_valid, tx_ready;
    logic [1:0] address;
    logic [7:0] data_in, rx_data;
    logic [7:0] data_out, tx_data;
    logic       data_oe, rx_ready, tx_valid, irq_n;

    cpu_mailbox #(.DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .clk_src(clk_src), .rst_n(rst_n), .cpu_clk_out(cpu_clk_out), .cs_n(cs_n), .rw(rw),
        .address(address), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq_n(irq_n)
    );

    always #10 clk_src = ~clk_src;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic       m_rx_ovf = 1'b0, m_tx_ovf = 1'b0, m_irq_en = 1'b0;
    logic [7:0] rd;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_src);
        #1;
    endtask

    function automatic logic [7:0] m_status();
        return {4'b0000, m_tx_ovf, m_rx_ovf, (tx_q.size() == DEPTH), (rx_q.size() != 0)};
    endfunction

    function automatic logic m_irq_n();
`ifdef CPU_MAILBOX_IRQ_EN
        return !(m_irq_en && rx_q.size() != 0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic cpu_cycle(input logic rw_v, input logic [1:0] a, input logic [7:0] d,
                             output logic [7:0] r);
        tick(1);
        cs_n = 1'b0; rw = rw_v; address = a; data_in = d; cpu_clk_out = 1'b1;
        tick(4);
        @(negedge clk_src);
        r = data_out;
        chk("data_oe", {7'b0, data_oe}, {7'b0, rw_v});
        tick(1);
        cpu_clk_out = 1'b0;
        tick(1);
        cs_n = 1'b1; rw = 1'b1;
        tick(SYNC + 3);
    endtask

    task automatic fpga_push(input logic [7:0] d);
        chk("rx_ready", {7'b0, rx_ready}, {7'b0, (rx_q.size() < DEPTH)});
        rx_valid = 1'b1; rx_data = d;
        tick(1);
        rx_valid = 1'b0;
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
        else                     m_rx_ovf = 1'b1;
    endtask

    task automatic cpu_read_data();
        logic [7:0] exp;
        exp = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        cpu_cycle(1'b1, 2'd0, 8'h00, rd);
        chk("read_data", rd, exp);
        if (rx_q.size() != 0) void'(rx_q.pop_front());
    endtask

    task automatic cpu_write_data(input logic [7:0] d);
        cpu_cycle(1'b0, 2'd0, d, rd);
        if (tx_q.size() < DEPTH) tx_q.push_back(d);
        else                     m_tx_ovf = 1'b1;
    endtask

    task automatic cpu_write_ctrl(input logic [7:0] v);
        cpu_cycle(1'b0, 2'd2, v, rd);
        if (v[0]) begin m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; end
        if (v[1]) begin rx_q.delete(); tx_q.delete(); end
`ifdef CPU_MAILBOX_IRQ_EN
        m_irq_en = v[2];
`endif
    endtask

    task automatic fpga_pop();
        chk("tx_valid", {7'b0, tx_valid}, {7'b0, (tx_q.size() != 0)});
        chk("tx_data", tx_data, (tx_q.size() != 0) ? tx_q[0] : 8'h00);
        if (tx_q.size() != 0) begin
            tx_ready = 1'b1;
            tick(1);
            tx_ready = 1'b0;
            void'(tx_q.pop_front());
        end
    endtask

    task automatic check_status(input string tag);
        cpu_cycle(1'b1, 2'd1, 8'h00, rd);
        chk(tag, rd, m_status());
        chk("irq_n", {7'b0, irq_n}, {7'b0, m_irq_n()});
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cpu_clk_out = 1'b0; cs_n = 1'b1; rw = 1'b1; address = 2'd0;
        data_in = 8'h00; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Reset asserted in the middle of a PHI2-high write cycle
        cs_n = 1'b0; rw = 1'b0; address = 2'd0; data_in = 8'h77; cpu_clk_out = 1'b1;
        tick(5);
        rst_n = 1'b0;
        tick(2);
        cpu_clk_out = 1'b0; cs_n = 1'b1; rw = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_irq_n", {7'b0, irq_n}, 8'h01);
        check_status("rst_status");

        // Two RX bytes read back in order, then an empty read
        fpga_push(8'h11);
        fpga_push(8'h22);
        cpu_read_data();
        cpu_read_data();
        check_status("rx_drained_status");
        cpu_read_data();
        check_status("rx_empty_read_status");

        // TX overflow with FPGA side stalled
        for (int i = 0; i < DEPTH + 1; i++) cpu_write_data(8'hA5);
        check_status("tx_ovf_status");
        for (int i = 0; i < DEPTH; i++) fpga_pop();
        chk("tx_empty_valid", {7'b0, tx_valid}, 8'h00);
        cpu_write_ctrl(8'h01);
        check_status("tx_ovf_cleared");

        // RX overflow, clear, then same-clock push and pop while full
        for (int i = 0; i < DEPTH; i++) fpga_push(8'h40 + 8'(i));
        fpga_push(8'hFF);
        check_status("rx_ovf_status");
        cpu_write_ctrl(8'h01);
        check_status("rx_ovf_cleared");
        tick(1);
        cs_n = 1'b0; rw = 1'b1; address = 2'd0; cpu_clk_out = 1'b1;
        tick(4);
        @(negedge clk_src);
        chk("full_head", data_out, rx_q[0]);
        tick(1);
        cpu_clk_out = 1'b0;
        tick(SYNC);
        rx_valid = 1'b1; rx_data = 8'hEE;
        tick(1);
        rx_valid = 1'b0; cs_n = 1'b1;
        void'(rx_q.pop_front());
        rx_q.push_back(8'hEE);
        tick(3);
        chk("full_still_full", {7'b0, rx_ready}, 8'h00);
        check_status("same_clk_status");
        for (int i = 0; i < DEPTH; i++) cpu_read_data();
        check_status("same_clk_drained");

        // Flush with both FIFOs partly full
        fpga_push(8'h01); fpga_push(8'h02); fpga_push(8'h03);
        cpu_write_data(8'hC1); cpu_write_data(8'hC2);
        cpu_write_ctrl(8'h03);
        check_status("flush_status");
        chk("flush_tx_valid", {7'b0, tx_valid}, 8'h00);

        // Interrupt behaviour
        cpu_write_ctrl(8'h04);
        cpu_cycle(1'b1, 2'd2, 8'h00, rd);
`ifdef CPU_MAILBOX_IRQ_EN
        chk("ctrl_read", rd, 8'h04);
`else
        chk("ctrl_read", rd, 8'h00);
`endif
        fpga_push(8'h5A);
        tick(2);
        chk("irq_after_push", {7'b0, irq_n}, {7'b0, m_irq_n()});
        cpu_read_data();
        chk("irq_after_read", {7'b0, irq_n}, 8'h01);
        cpu_write_ctrl(8'h00);

        // Randomized traffic against the queue model
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 5))
                0, 1:    fpga_push(8'($urandom_range(0, 255)));
                2:       cpu_read_data();
                3:       cpu_write_data(8'($urandom_range(0, 255)));
                4:       fpga_pop();
                default: check_status("rand_status");
            endcase
            if (k % 50 == 49) cpu_write_ctrl(8'h01);
        end
        check_status("final_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
